// File: rtl/regfile_xfer_pkg.sv
// Shared types and constants for the register-list load/store sequencer.
package regfile_xfer_pkg;

  localparam int WORD_BYTES = 4;
  localparam int PC_INDEX   = 15;
  localparam int NUM_REGS   = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WRITE,
    DONE
  } xfer_state_t;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [3:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/lowest_set_bit16.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit mask.
module lowest_set_bit16 (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Scan downward so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      if (mask_i[k]) begin
        idx_o = 4'(k);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_block_transfer.sv
// Multi-register load/store sequencer: walks a register mask low-to-high,
// moving one word per listed register between the register file and memory.
module regfile_block_transfer
  import regfile_xfer_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [15:0]       reg_list,
  input  logic [DATA_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] RD1,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              pc_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  xfer_state_t       state_q;
  logic [15:0]       mask_q;
  logic [15:0]       mask_d;
  logic [DATA_W-1:0] addr_q;
  logic [3:0]        idx_q;
  logic              is_load_q;

  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] a1_q;
  logic [ADDR_W-1:0] a3_q;
  logic [DATA_W-1:0] wd3_q;
  logic              we3_q;
  logic              pc_we_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [3:0]        nxt_idx;
  logic              nxt_any;

  // Mask as it will be after the current register retires; in WRITE the bit
  // is already clear, so clearing it again is harmless.
  always_comb begin
    mask_d = mask_q & ~idx_onehot(idx_q);
    if (state_q == IDLE) begin
      mask_d = reg_list;
    end
  end

  lowest_set_bit16 u_lsb (
    .mask_i (mask_d),
    .idx_o  (nxt_idx),
    .any_o  (nxt_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      is_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a1_q        <= '0;
      a3_q        <= '0;
      wd3_q       <= '0;
      we3_q       <= 1'b0;
      pc_we_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      we3_q   <= 1'b0;
      pc_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_load_q <= is_load;
            mask_q    <= mask_d;
            addr_q    <= base_addr;
            busy_q    <= 1'b1;
            if (nxt_any) begin
              state_q <= ISSUE;
              idx_q   <= nxt_idx;
              if (!is_load) a1_q <= ADDR_W'(nxt_idx);
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        // A1 was registered on entry, so RD1 is valid to capture here.
        ISSUE: begin
          mem_req_q  <= 1'b1;
          mem_we_q   <= !is_load_q;
          mem_addr_q <= addr_q;
          if (!is_load_q) mem_wdata_q <= RD1;
          state_q    <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mask_q    <= mask_d;
            addr_q    <= addr_q + DATA_W'(WORD_BYTES);
            if (is_load_q) begin
              wd3_q   <= mem_rdata;
              a3_q    <= ADDR_W'(idx_q);
              we3_q   <= (idx_q != 4'(PC_INDEX));
              pc_we_q <= (idx_q == 4'(PC_INDEX));
              state_q <= WRITE;
            end else if (nxt_any) begin
              state_q <= ISSUE;
              idx_q   <= nxt_idx;
              a1_q    <= ADDR_W'(nxt_idx);
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (nxt_any) begin
            state_q <= ISSUE;
            idx_q   <= nxt_idx;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign A1        = a1_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign WE3       = we3_q;
  assign pc_we     = pc_we_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_regfile_block_transfer.sv
// Randomized bench for the register-list sequencer with a transfer-level reference model.
module tb_regfile_block_transfer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_load;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic [8:0]  A1;
  logic [31:0] RD1;
  logic [8:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        pc_we;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] regs [16];
  logic [31:0] mem [logic [31:0]];

  regfile_block_transfer #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .A1        (A1),
    .RD1       (RD1),
    .A3        (A3),
    .WD3       (WD3),
    .WE3       (WE3),
    .pc_we     (pc_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  assign RD1 = regs[A1[3:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {58'd0, busy, done, WE3, pc_we, mem_req, mem_we}, 64'd0);
    chk({tag, "_a13"}, {46'd0, A1, A3}, 64'd0);
    chk({tag, "_wd3"}, {32'd0, WD3}, 64'd0);
    chk({tag, "_maddr"}, {32'd0, mem_addr}, 64'd0);
    chk({tag, "_mwdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  // One complete transfer. Expected memory traffic, register writes and
  // latency come from the list/base/memory contents alone.
  task automatic run_xfer(input logic ld, input logic [15:0] list,
                          input logic [31:0] base, input int fixed_d);
    logic [31:0] exp_addr[$];
    logic [31:0] exp_wdata[$];
    logic [3:0]  exp_widx[$];
    logic [31:0] exp_wdat[$];
    logic [31:0] a, held_addr, held_wdata;
    logic        held_we;
    int          j, cyc, exp_lat, wait_cnt, d;
    bit          in_req, fin;

    j = 0;
    for (int k = 0; k < 16; k++) begin
      if (list[k]) begin
        a = base + 32'(4 * j);
        exp_addr.push_back(a);
        if (ld) begin
          exp_widx.push_back(4'(k));
          exp_wdat.push_back(mem_rd(a));
        end else begin
          exp_wdata.push_back(regs[k]);
        end
        j++;
      end
    end

    exp_lat  = 1;
    in_req   = 0;
    fin      = 0;
    cyc      = 0;
    wait_cnt = 0;
    d        = 0;
    held_addr = '0; held_wdata = '0; held_we = 1'b0;
    start     = 1'b1;
    is_load   = ld;
    reg_list  = list;
    base_addr = base;

    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (cyc == 1 && list != 16'd0) begin
        start     = 1'b1;
        is_load   = ~ld;
        reg_list  = 16'($urandom);
        base_addr = $urandom;
      end

      chk("busy", busy, 1);

      if (mem_req) begin
        if (!in_req) begin
          in_req   = 1;
          wait_cnt = 0;
          d        = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 3));
          exp_lat += 2 + d + (ld ? 1 : 0);
          held_addr  = mem_addr;
          held_wdata = mem_wdata;
          held_we    = mem_we;
          if (exp_addr.size() == 0) begin
            chk("unexp_req", 1, 0);
          end else begin
            chk("mem_addr", mem_addr, exp_addr[0]);
            chk("mem_we", mem_we, !ld);
            if (!ld) chk("mem_wdata", mem_wdata, exp_wdata[0]);
          end
        end else begin
          wait_cnt++;
          chk("hold_addr", mem_addr, held_addr);
          chk("hold_wdata", mem_wdata, held_wdata);
          chk("hold_we", mem_we, held_we);
        end
        if (wait_cnt == d) begin
          mem_ack = 1'b1;
          in_req  = 0;
          if (exp_addr.size() > 0) begin
            if (ld) begin
              mem_rdata = mem_rd(exp_addr[0]);
            end else if (exp_wdata.size() > 0) begin
              mem[exp_addr[0]] = exp_wdata[0];
              void'(exp_wdata.pop_front());
            end
            void'(exp_addr.pop_front());
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
      end

      if (WE3) begin
        chk("we3_pc_excl", pc_we, 0);
        if (exp_widx.size() == 0) begin
          chk("unexp_we3", 1, 0);
        end else begin
          chk("a3", A3, {5'd0, exp_widx[0]});
          chk("wd3", WD3, exp_wdat[0]);
          void'(exp_widx.pop_front());
          void'(exp_wdat.pop_front());
        end
        regs[A3[3:0]] = WD3;
      end
      if (pc_we) begin
        if (exp_widx.size() == 0) begin
          chk("unexp_pc_we", 1, 0);
        end else begin
          chk("pc_we_idx", 15, exp_widx[0]);
          chk("pc_wd3", WD3, exp_wdat[0]);
          void'(exp_widx.pop_front());
          void'(exp_wdat.pop_front());
        end
      end

      if (done) begin
        chk("latency", cyc, exp_lat);
        fin = 1;
      end
    end

    if (!fin) chk("timeout_done", 0, 1);
    chk("reqs_left", exp_addr.size(), 0);
    chk("writes_left", exp_widx.size(), 0);
    chk("a_upper", {A1[8:4], A3[8:4]}, 0);

    @(negedge clk);
    mem_ack = 1'b0;
    start   = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Reset lands while the second word of a three-register load is pending.
  task automatic reset_mid_load();
    int nreq;
    bit hit;
    nreq = 0;
    hit  = 0;
    start     = 1'b1;
    is_load   = 1'b1;
    reg_list  = 16'h0007;
    base_addr = 32'h0000_0300;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      start   = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        nreq++;
        if (nreq == 1) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'h0000_1111;
        end else begin
          hit = 1;
        end
      end
    end
    if (!hit) chk("rst_reach_wait", 0, 1);
    rst = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", {WE3, pc_we, mem_req, busy, done}, 0);
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] lst;
    int r;
    rst = 1'b0; start = 1'b0; is_load = 1'b0; reg_list = '0; base_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 16; k++) regs[k] = $urandom;

    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    regs[1] = 32'h1234_5678;
    regs[2] = 32'h8765_4321;
    run_xfer(1'b0, 16'h0006, 32'h0000_0100, 0);
    chk("st_mem100", mem_rd(32'h100), 32'h1234_5678);
    chk("st_mem104", mem_rd(32'h104), 32'h8765_4321);

    mem[32'h200] = 32'hAAAA_0001;
    mem[32'h204] = 32'h0000_0040;
    run_xfer(1'b1, 16'h8001, 32'h0000_0200, 1);
    chk("ld_r0", regs[0], 32'hAAAA_0001);

    run_xfer(1'b0, 16'h0000, 32'h0000_0400, 0);
    run_xfer(1'b1, 16'h0000, 32'h0000_0500, 0);

    run_xfer(1'b0, 16'h0003, 32'hFFFF_FFFC, 0);
    chk("wrap_lo", mem_rd(32'h0000_0000), regs[1]);

    run_xfer(1'b0, 16'h8421, 32'h0000_0800, 5);
    run_xfer(1'b1, 16'h0030, 32'h0000_0900, 5);

    reset_mid_load();
    run_xfer(1'b1, 16'h0007, 32'h0000_0300, 0);

    for (int t = 0; t < 24; t++) begin
      r = int'($urandom_range(0, 9));
      lst = 16'($urandom);
      if (r == 0) lst = 16'h0000;
      else if (r == 1) lst = lst | 16'h8000;
      for (int k = 0; k < 16; k++) regs[k] = $urandom;
      run_xfer(1'($urandom), lst, $urandom, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
